i2s_frame_feeder: RTL and testbench

Upstream stage of the I2S serializer. Derives SCLK and LRCLK from the 50 MHz system clock and buffers incoming 24-bit mono samples in a small FIFO. Presents one sample per stereo frame on data_out, changing it only at frame boundaries. The serializer consumes SCLK, LRCLK and data_out; the synth voice/mixer feeds s_data over a valid/ready handshake.

---
 rtl/audio_pkg.sv | 9 +
 rtl/sample_fifo.sv | 69 ++++++
 rtl/i2s_frame_feeder.sv | 119 +++++++++++
 tb/tb_i2s_frame_feeder.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared audio constants and the sample type.
// The mixer, this feeder and the serializer all use it.
package audio_pkg;
  localparam int SAMPLE_W        = 24;
  localparam int DEF_SCLK_DIV    = 8;
  localparam int DEF_BITS_PER_CH = 32;

  typedef logic [SAMPLE_W-1:0] sample_t;
endpackage

// File: rtl/sample_fifo.sv
// Synchronous FIFO with occupancy count. Push is ignored when full and pop is
// ignored when empty. DEPTH must be a power of two so the pointers wrap naturally.
module sample_fifo #(
  parameter int W     = 24,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             wr_data,
  input  logic                     pop,
  output logic [W-1:0]             rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by count_q.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end
endmodule

// File: rtl/i2s_frame_feeder.sv
// Generates SCLK/LRCLK from the system clock and presents one buffered sample
// per stereo frame on data_out, updated only at frame start.
// s_data/s_valid/s_ready: a sample is taken on any cycle where s_valid && s_ready.
module i2s_frame_feeder
  import audio_pkg::*;
#(
  parameter int SCLK_DIV    = DEF_SCLK_DIV,
  parameter int BITS_PER_CH = DEF_BITS_PER_CH,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic                          enable,
  input  sample_t                       s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic                          underrun_clr,
  output logic                          SCLK,
  output logic                          LRCLK,
  output sample_t                       data_out,
  output logic                          sample_tick,
  output logic                          underrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int FRAME_BITS = 2 * BITS_PER_CH;
  localparam int DIV_W      = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam int BIT_W      = $clog2(FRAME_BITS);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             sclk_q, sclk_d;
  logic             lrclk_q, lrclk_d;
  sample_t          data_q, data_d;
  logic             tick_q, tick_d;
  logic             underrun_q, underrun_d;
  logic             div_tc, bit_wrap, pop;

  sample_t          fifo_rd;
  logic             fifo_full, fifo_empty;

  sample_fifo #(.W(SAMPLE_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (Clk),
    .rst     (Reset),
    .push    (s_valid),
    .wr_data (s_data),
    .pop     (pop),
    .rd_data (fifo_rd),
    .count   (fifo_level),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign s_ready = !fifo_full;

  always_comb begin
    div_cnt_d  = div_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    sclk_d     = sclk_q;
    lrclk_d    = lrclk_q;
    data_d     = data_q;
    tick_d     = 1'b0;
    underrun_d = underrun_q && !underrun_clr;
    pop        = 1'b0;
    div_tc     = (div_cnt_q == DIV_W'(SCLK_DIV - 1));
    bit_wrap   = (bit_cnt_q == BIT_W'(FRAME_BITS - 1));
    if (!enable) begin
      div_cnt_d = '0;
      bit_cnt_d = '0;
      sclk_d    = 1'b0;
      lrclk_d   = 1'b0;
    end else begin
      div_cnt_d = div_tc ? '0 : div_cnt_q + 1'b1;
      if (div_tc) begin
        sclk_d = !sclk_q;
        // Bit counter and word select move only on SCLK falling edges.
        if (sclk_q) begin
          bit_cnt_d = bit_wrap ? '0 : bit_cnt_q + 1'b1;
          lrclk_d   = (bit_cnt_d >= BIT_W'(BITS_PER_CH));
          if (bit_wrap) begin
            tick_d = 1'b1;
            if (fifo_empty) begin
              data_d     = '0;
              underrun_d = 1'b1;
            end else begin
              data_d = fifo_rd;
              pop    = 1'b1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      div_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      sclk_q     <= 1'b0;
      lrclk_q    <= 1'b0;
      data_q     <= '0;
      tick_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      div_cnt_q  <= div_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      sclk_q     <= sclk_d;
      lrclk_q    <= lrclk_d;
      data_q     <= data_d;
      tick_q     <= tick_d;
      underrun_q <= underrun_d;
    end
  end

  assign SCLK        = sclk_q;
  assign LRCLK       = lrclk_q;
  assign data_out    = data_q;
  assign sample_tick = tick_q;
  assign underrun    = underrun_q;
endmodule

// File: tb/tb_i2s_frame_feeder.sv
// Bench for i2s_frame_feeder with a fast divider (SCLK_DIV=2).
module tb_i2s_frame_feeder;
  localparam int DIV        = 2;
  localparam int BPC        = 32;
  localparam int DEPTH      = 4;
  localparam int FRAME_CLKS = 2 * BPC * 2 * DIV;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        enable = 1'b0;
  logic [23:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic        underrun_clr = 1'b0;
  logic        SCLK, LRCLK, sample_tick, underrun;
  logic [23:0] data_out;
  logic [2:0]  fifo_level;

  i2s_frame_feeder #(.SCLK_DIV(DIV), .BITS_PER_CH(BPC), .FIFO_DEPTH(DEPTH)) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .enable       (enable),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .underrun_clr (underrun_clr),
    .SCLK         (SCLK),
    .LRCLK        (LRCLK),
    .data_out     (data_out),
    .sample_tick  (sample_tick),
    .underrun     (underrun),
    .fifo_level   (fifo_level)
  );

  always #5 Clk = ~Clk;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: enabled-cycle count, queue of samples, output state.
  int          m_n = 0;
  logic [23:0] exp_q[$];
  logic [23:0] m_data = '0;
  logic        m_und = 1'b0;
  logic        m_tick = 1'b0;
  logic        last_push = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40) $display("FAIL %s t=%0t got=%h want=%h", name, $time, act, exp);
    end
  endtask

  // Apply one cycle of inputs, advance the model, then compare all outputs.
  task automatic cycle(input logic rst, input logic en, input logic sv,
                       input logic [23:0] sd, input logic clr);
    int  pre;
    int  f;
    logic fs;
    logic und_n;
    Reset = rst; enable = en; s_valid = sv; s_data = sd; underrun_clr = clr;
    pre = exp_q.size();
    last_push = 1'b0;
    if (rst) begin
      m_n = 0; exp_q.delete(); m_data = '0; m_und = 1'b0; m_tick = 1'b0;
    end else begin
      fs = 1'b0;
      if (en) begin
        m_n++;
        fs = (m_n % FRAME_CLKS) == 0;
      end else begin
        m_n = 0;
      end
      m_tick = fs;
      und_n  = m_und && !clr;
      if (fs) begin
        if (pre > 0) m_data = exp_q.pop_front();
        else begin
          m_data = '0;
          und_n  = 1'b1;
        end
      end
      if (sv && pre < DEPTH) begin
        exp_q.push_back(sd);
        last_push = 1'b1;
      end
      m_und = und_n;
    end
    @(posedge Clk);
    #1;
    f = m_n / (2 * DIV);
    chk("sclk", 32'(SCLK), 32'((m_n / DIV) % 2));
    chk("lrclk", 32'(LRCLK), 32'((f % (2 * BPC)) >= BPC));
    chk("data_out", 32'(data_out), 32'(m_data));
    chk("sample_tick", 32'(sample_tick), 32'(m_tick));
    chk("underrun", 32'(underrun), 32'(m_und));
    chk("fifo_level", 32'(fifo_level), 32'(exp_q.size()));
    chk("s_ready", 32'(s_ready), 32'(exp_q.size() < DEPTH));
  endtask

  // Advance with enable high until the next cycle is a frame start.
  task automatic run_to_frame_edge();
    for (int i = 0; i < FRAME_CLKS + 8; i++) begin
      if (((m_n + 1) % FRAME_CLKS) == 0) return;
      cycle(1'b0, 1'b1, 1'b0, '0, 1'b0);
    end
    chk("frame_edge_timeout", 32'd1, 32'd0);
  endtask

  typedef struct {
    logic        rst;
    logic        sv;
    logic [23:0] sd;
    logic        exp_ready;
    logic [2:0]  exp_level;
  } vec_t;

  vec_t vecs[9];
  logic [23:0] words[5];
  int c;
  int idx;
  logic prev_tick;
  logic saw_full;

  initial begin
    // Push/fill table with audio clocks idle.
    vecs[0] = '{1'b1, 1'b0, 24'h000000, 1'b1, 3'd0};
    vecs[1] = '{1'b0, 1'b1, 24'h111111, 1'b1, 3'd1};
    vecs[2] = '{1'b0, 1'b1, 24'h222222, 1'b1, 3'd2};
    vecs[3] = '{1'b0, 1'b0, 24'h999999, 1'b1, 3'd2};
    vecs[4] = '{1'b0, 1'b1, 24'h333333, 1'b1, 3'd3};
    vecs[5] = '{1'b0, 1'b1, 24'h444444, 1'b0, 3'd4};
    vecs[6] = '{1'b0, 1'b1, 24'h555555, 1'b0, 3'd4};
    vecs[7] = '{1'b1, 1'b1, 24'h666666, 1'b1, 3'd0};
    vecs[8] = '{1'b0, 1'b0, 24'h000000, 1'b1, 3'd0};

    cycle(1'b1, 1'b0, 1'b0, '0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, '0, 1'b0);
    chk("rst_sclk", 32'(SCLK), 32'd0);
    chk("rst_lrclk", 32'(LRCLK), 32'd0);
    chk("rst_data", 32'(data_out), 32'd0);
    chk("rst_tick", 32'(sample_tick), 32'd0);
    chk("rst_und", 32'(underrun), 32'd0);
    chk("rst_ready", 32'(s_ready), 32'd1);
    chk("rst_level", 32'(fifo_level), 32'd0);

    for (int i = 0; i < 9; i++) begin
      cycle(vecs[i].rst, 1'b0, vecs[i].sv, vecs[i].sd, 1'b0);
      chk("tbl_ready", 32'(s_ready), 32'(vecs[i].exp_ready));
      chk("tbl_level", 32'(fifo_level), 32'(vecs[i].exp_level));
      chk("tbl_sclk", 32'(SCLK), 32'd0);
    end

    // Two samples before the first frame; first tick 256 cycles after enable.
    cycle(1'b1, 1'b0, 1'b0, '0, 1'b0);
    c = 0;
    for (int i = 1; i <= 400; i++) begin
      cycle(1'b0, 1'b1, i <= 2, (i == 1) ? 24'h123456 : 24'hABCDEF, 1'b0);
      if (sample_tick) begin c = i; break; end
    end
    chk("first_tick_cyc", 32'(c), 32'd256);
    chk("tick1_data", 32'(data_out), 32'h123456);
    chk("tick1_level", 32'(fifo_level), 32'd1);
    for (int i = 0; i < 300; i++) begin
      cycle(1'b0, 1'b1, 1'b0, '0, 1'b0);
      if (sample_tick) break;
      chk("hold_data", 32'(data_out), 32'h123456);
    end
    chk("tick2_data", 32'(data_out), 32'hABCDEF);
    chk("tick2_level", 32'(fifo_level), 32'd0);

    // Empty frame start: underrun, then clear, then clear loses to a new event.
    run_to_frame_edge();
    cycle(1'b0, 1'b1, 1'b0, '0, 1'b0);
    chk("und_data", 32'(data_out), 32'd0);
    chk("und_set", 32'(underrun), 32'd1);
    cycle(1'b0, 1'b1, 1'b0, '0, 1'b1);
    chk("und_clr", 32'(underrun), 32'd0);
    run_to_frame_edge();
    cycle(1'b0, 1'b1, 1'b0, '0, 1'b1);
    chk("und_set_wins", 32'(underrun), 32'd1);

    // Push exactly on an empty frame start: no bypass.
    run_to_frame_edge();
    cycle(1'b0, 1'b1, 1'b1, 24'h55AA11, 1'b0);
    chk("nobyp_und", 32'(underrun), 32'd1);
    chk("nobyp_data", 32'(data_out), 32'd0);
    chk("nobyp_level", 32'(fifo_level), 32'd1);
    cycle(1'b0, 1'b1, 1'b0, '0, 1'b1);
    run_to_frame_edge();
    cycle(1'b0, 1'b1, 1'b0, '0, 1'b0);
    chk("nobyp_next", 32'(data_out), 32'h55AA11);

    // Fill with s_valid held; the 5th word waits for the next pop.
    words[0] = 24'hA00001; words[1] = 24'hA00002; words[2] = 24'hA00003;
    words[3] = 24'hA00004; words[4] = 24'hA00005;
    idx = 0; prev_tick = 1'b0; saw_full = 1'b0;
    for (int i = 0; i < 600 && idx < 5; i++) begin
      cycle(1'b0, 1'b1, 1'b1, words[idx], 1'b0);
      if (last_push && idx == 4) chk("fifth_after_tick", 32'(prev_tick), 32'd1);
      if (sample_tick) chk("fill_order", 32'(data_out), 32'(words[0]));
      if (last_push) idx++;
      if (fifo_level == 3'd4 && !saw_full) begin
        saw_full = 1'b1;
        chk("full_ready", 32'(s_ready), 32'd0);
      end
      prev_tick = sample_tick;
    end
    chk("fill_done", 32'(idx), 32'd5);

    // Reset mid-frame with three entries queued.
    run_to_frame_edge();
    cycle(1'b0, 1'b1, 1'b0, '0, 1'b0);
    chk("pop_order", 32'(data_out), 32'(words[1]));
    for (int i = 0; i < 150; i++) cycle(1'b0, 1'b1, 1'b0, '0, 1'b0);
    chk("pre_rst_level", 32'(fifo_level), 32'd3);
    cycle(1'b1, 1'b1, 1'b0, '0, 1'b0);
    chk("mrst_sclk", 32'(SCLK), 32'd0);
    chk("mrst_lrclk", 32'(LRCLK), 32'd0);
    chk("mrst_data", 32'(data_out), 32'd0);
    chk("mrst_level", 32'(fifo_level), 32'd0);
    chk("mrst_ready", 32'(s_ready), 32'd1);

    // enable dropped mid-frame while LRCLK is high.
    cycle(1'b0, 1'b1, 1'b1, 24'h0BEEF0, 1'b0);
    for (int i = 0; i < FRAME_CLKS + FRAME_CLKS / 2 + 9; i++) cycle(1'b0, 1'b1, 1'b0, '0, 1'b0);
    chk("pre_dis_lrclk", 32'(LRCLK), 32'd1);
    cycle(1'b0, 1'b0, 1'b0, '0, 1'b0);
    chk("dis_sclk", 32'(SCLK), 32'd0);
    chk("dis_lrclk", 32'(LRCLK), 32'd0);
    chk("dis_data", 32'(data_out), 32'h0BEEF0);

    // Randomized traffic against the model.
    for (int i = 0; i < 6000; i++) begin
      cycle($urandom_range(0, 999) == 0,
            $urandom_range(0, 299) != 0,
            $urandom_range(0, 149) == 0,
            24'($urandom),
            $urandom_range(0, 199) == 0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
